// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter with a valid/ready load handshake, selectable bit order,
// serial clock enable and end-of-frame marker. Define PISO_PARITY_EN to append an even-parity bit.
module piso_shifter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] Din,
  input  logic             shift_en,
  output logic             Dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift
`ifdef PISO_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             last_q, last_d;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic             accept;

  // Position cnt counts in transmission order; map it onto the word's bit index.
  function automatic logic sel_bit(input logic [WIDTH-1:0] w, input logic [CntW-1:0] c);
    logic [CntW-1:0] idx;
    idx = MSB_FIRST ? (LastIdx - c) : c;
    return |(w & (WIDTH'(1) << idx));
  endfunction

  assign load_ready = (state_q == StIdle) | (last_q & shift_en);
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    last_d       = last_q;
`ifdef PISO_PARITY_EN
    parity_d     = parity_q;
`endif
    if (accept) begin
      // Covers both a load from idle and a reload on the edge consuming the last bit.
      state_d      = StShift;
      shreg_d      = Din;
      cnt_d        = '0;
      dout_d       = sel_bit(Din, '0);
      dout_valid_d = 1'b1;
      last_d       = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d     = ^Din;
`endif
    end else if (shift_en) begin
      unique case (state_q)
        StIdle: begin
        end
        StShift: begin
          if (cnt_q == LastIdx) begin
`ifdef PISO_PARITY_EN
            state_d = StParity;
            cnt_d   = cnt_q + 1'b1;
            dout_d  = parity_q;
            last_d  = 1'b1;
`else
            state_d      = StIdle;
            cnt_d        = '0;
            dout_d       = 1'b0;
            dout_valid_d = 1'b0;
            last_d       = 1'b0;
`endif
          end else begin
            cnt_d  = cnt_q + 1'b1;
            dout_d = sel_bit(shreg_q, cnt_q + 1'b1);
`ifdef PISO_PARITY_EN
            last_d = 1'b0;
`else
            last_d = ((cnt_q + 1'b1) == LastIdx);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        StParity: begin
          state_d      = StIdle;
          cnt_d        = '0;
          dout_d       = 1'b0;
          dout_valid_d = 1'b0;
          last_d       = 1'b0;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shreg_q      <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      last_q       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_q       <= last_d;
`ifdef PISO_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign Dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign last       = last_q;
  assign busy       = dout_valid_q;

endmodule
